// File: rtl/mac_row_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mac_row_gen
//  Description : One row of multiply-accumulate columns for a systolic array.
//                Weight-stationary and output-stationary modes, with a
//                one-cycle skew per column.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_row_gen #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int sat     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [bw-1:0]          in_w,
    input  logic [2:0]             inst_w,
    input  logic [psum_bw*col-1:0] in_n,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid,
    output logic [bw-1:0]          out_e,
    output logic [2:0]             inst_e
);

    localparam logic [psum_bw-1:0] c_psum_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] c_psum_min = {1'b1, {(psum_bw-1){1'b0}}};

    // Signed bw x bw product, sign-extended to the partial-sum width.
    function automatic logic [psum_bw-1:0] mul_f(input logic [bw-1:0] x,
                                                  input logic [bw-1:0] y);
        logic signed [psum_bw-1:0] xe;
        logic signed [psum_bw-1:0] ye;
        xe = psum_bw'($signed(x));
        ye = psum_bw'($signed(y));
        return xe * ye;
    endfunction

    // Overflow shows as disagreement between the two top bits of the extended sum.
    function automatic logic [psum_bw-1:0] add_f(input logic [psum_bw-1:0] x,
                                                  input logic [psum_bw-1:0] y);
        logic [psum_bw:0] s;
        s = {x[psum_bw-1], x} + {y[psum_bw-1], y};
        if ((sat != 0) && (s[psum_bw] != s[psum_bw-1])) begin
            return s[psum_bw] ? c_psum_min : c_psum_max;
        end
        return s[psum_bw-1:0];
    endfunction

    logic [bw-1:0] w_a_out    [col];
    logic [2:0]    w_inst_out [col];

    generate
        for (genvar k = 0; k < col; k++) begin : g_col
            logic [bw-1:0]      w_op_in;
            logic [2:0]         w_inst_in;
            logic [psum_bw-1:0] w_n;
            logic [psum_bw-1:0] w_prod_ws;
            logic [psum_bw-1:0] w_prod_os;

            logic [bw-1:0]      a_q, a_d;
            logic [bw-1:0]      b_q, b_d;
            logic [psum_bw-1:0] c_q, c_d;
            logic [2:0]         inst_q, inst_d;
            logic               load_ready_q, load_ready_d;
            logic [psum_bw-1:0] out_q, out_d;
            logic               vld_q, vld_d;

            if (k == 0) begin : g_head
                assign w_op_in   = in_w;
                assign w_inst_in = inst_w;
            end else begin : g_chain
                assign w_op_in   = w_a_out[k-1];
                assign w_inst_in = w_inst_out[k-1];
            end

            assign w_n       = in_n[psum_bw*k +: psum_bw];
            assign w_prod_ws = mul_f(w_op_in, b_q);
            assign w_prod_os = mul_f(w_op_in, w_n[bw-1:0]);

            always_comb begin
                a_d          = a_q;
                b_d          = b_q;
                c_d          = c_q;
                load_ready_d = load_ready_q;
                out_d        = out_q;
                vld_d        = 1'b0;

                if (w_inst_in[1] || w_inst_in[0]) begin
                    a_d = w_op_in;
                end

                // A loaded column swallows the load bit so the next load lands further east.
                inst_d = {w_inst_in[2], w_inst_in[1],
                          w_inst_in[2] ? w_inst_in[0] : (w_inst_in[0] & ~load_ready_q)};

                if (!w_inst_in[2]) begin
                    if (w_inst_in[0] && load_ready_q) begin
                        b_d          = w_op_in;
                        load_ready_d = 1'b0;
                    end else if (w_inst_in[1]) begin
                        out_d = add_f(w_n, w_prod_ws);
                        vld_d = 1'b1;
                    end
                end else begin
                    if (w_inst_in[0]) begin
                        out_d = w_inst_in[1] ? add_f(c_q, w_prod_os) : c_q;
                        c_d   = '0;
                        vld_d = 1'b1;
                    end else if (w_inst_in[1]) begin
                        c_d   = add_f(c_q, w_prod_os);
                        out_d = psum_bw'($signed(w_n[bw-1:0]));
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q          <= '0;
                    b_q          <= '0;
                    c_q          <= '0;
                    inst_q       <= '0;
                    load_ready_q <= 1'b1;
                    out_q        <= '0;
                    vld_q        <= 1'b0;
                end else begin
                    a_q          <= a_d;
                    b_q          <= b_d;
                    c_q          <= c_d;
                    inst_q       <= inst_d;
                    load_ready_q <= load_ready_d;
                    out_q        <= out_d;
                    vld_q        <= vld_d;
                end
            end

            assign w_a_out[k]                    = a_q;
            assign w_inst_out[k]                 = inst_q;
            assign out_s[psum_bw*k +: psum_bw]   = out_q;
            assign valid[k]                      = vld_q;
        end
    endgenerate

    assign out_e  = w_a_out[col-1];
    assign inst_e = w_inst_out[col-1];

endmodule
`default_nettype wire

// File: tb/tb_mac_row_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_row_gen
//  Description : Self-checking bench for mac_row_gen (wrapping and saturating
//                instances driven in parallel).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_row_gen;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_w;
    logic [2:0]   inst_w;
    logic [127:0] in_n;

    logic [127:0] out_s0, out_s1;
    logic [7:0]   valid0, valid1;
    logic [3:0]   out_e0, out_e1;
    logic [2:0]   inst_e0, inst_e1;

    mac_row_gen #(.bw(4), .psum_bw(16), .col(8), .sat(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
        .out_s(out_s0), .valid(valid0), .out_e(out_e0), .inst_e(inst_e0)
    );

    mac_row_gen #(.bw(4), .psum_bw(16), .col(8), .sat(1)) u_dut_sat (
        .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
        .out_s(out_s1), .valid(valid1), .out_e(out_e1), .inst_e(inst_e1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int ecnt   = 0;
    bit sb_on  = 1'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int         cyc;
        int         k;
        logic [15:0] val;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [3:0]        w;
        logic [15:0]       n;
        logic [7:0][15:0]  e;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [2:0] i, input logic [3:0] w, input logic [15:0] n);
        inst_w = i;
        in_w   = w;
        in_n   = {8{n}};
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [7:0][15:0] e);
        for (int k = 0; k < 8; k++) sb.push_back('{ecnt + 1 + k, k, e[k]});
    endtask

    task automatic push_all(input logic [15:0] v);
        push_row({8{v}});
    endtask

    task automatic drain();
        inst_w = 3'b000;
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drv(3'b000, 4'd0, 16'd0);
        reset = 1'b0;
    endtask

    // Compare the wrapping instance against every expected entry due this cycle,
    // and flag any valid bit that has no expected entry.
    always @(negedge clk) begin : p_sb
        int         i;
        logic [7:0] m;
        if (sb_on) begin
            m = '0;
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].cyc == ecnt) begin
                    m[sb[i].k] = 1'b1;
                    checks++;
                    if (out_s0[sb[i].k*16 +: 16] !== sb[i].val) begin
                        fails++;
                        $display("FAIL sb_col%0d cyc=%0d actual=%h expected=%h",
                                 sb[i].k, ecnt, out_s0[sb[i].k*16 +: 16], sb[i].val);
                    end
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
            checks++;
            if (valid0 !== m) begin
                fails++;
                $display("FAIL valid_mask cyc=%0d actual=%b expected=%b", ecnt, valid0, m);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : p_main
        logic [3:0] wv [8];
        int         e0;

        tbl[0] = '{4'd2,  16'd0,
                   {16'hFFF0, 16'd14, 16'd12, 16'd10, 16'd8, 16'd6, 16'd4, 16'd2}};
        tbl[1] = '{4'hF,  16'd100,
                   {16'd108, 16'd93, 16'd94, 16'd95, 16'd96, 16'd97, 16'd98, 16'd99}};
        tbl[2] = '{4'd7,  16'h7FF0,
                   {16'h7FB8, 16'h8021, 16'h801A, 16'h8013, 16'h800C, 16'h8005, 16'h7FFE, 16'h7FF7}};
        tbl[3] = '{4'h8,  16'hFFFF,
                   {16'h003F, 16'hFFC7, 16'hFFCF, 16'hFFD7, 16'hFFDF, 16'hFFE7, 16'hFFEF, 16'hFFF7}};
        tbl[4] = '{4'd0,  16'h1234, {8{16'h1234}}};
        wv = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'h8};

        // Reset held two cycles under random inputs.
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            inst_w = 3'($urandom);
            in_w   = 4'($urandom);
            in_n   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        chk("rst_out_s0",  {31'd0, |out_s0}, 32'd0);
        chk("rst_valid0",  {24'd0, valid0},  32'd0);
        chk("rst_out_e0",  {28'd0, out_e0},  32'd0);
        chk("rst_inst_e0", {29'd0, inst_e0}, 32'd0);
        chk("rst_out_s1",  {31'd0, |out_s1}, 32'd0);
        chk("rst_valid1",  {24'd0, valid1},  32'd0);
        reset  = 1'b0;
        inst_w = 3'b000;
        in_w   = 4'd0;
        in_n   = '0;
        sb_on  = 1'b1;

        // Weight-stationary load of 1..7,-8 then table-driven executes.
        for (int i = 0; i < 8; i++) drv(3'b001, wv[i], 16'd0);
        drain();
        for (int r = 0; r < 5; r++) begin
            push_row(tbl[r].e);
            drv(3'b010, tbl[r].w, tbl[r].n);
            drain();
        end

        // A ninth load finds no free column and leaves through the east edge.
        e0 = ecnt;
        drv(3'b001, 4'd5, 16'd0);
        inst_w = 3'b000;
        for (int t = 0; t < 20 && ecnt != e0 + 8; t++) @(negedge clk);
        chk("east_wait",   ecnt,                e0 + 8);
        chk("east_inst_e", {29'd0, inst_e0},    32'd1);
        chk("east_out_e",  {28'd0, out_e0},     32'd5);
        drain();

        // Output-stationary: three accumulates of 3*2 then flush, then flush of cleared state.
        drv(3'b110, 4'd3, 16'd2);
        chk("os_fwd_col0",   {16'd0, out_s0[15:0]}, 32'd2);
        chk("os_fwd_valid0", {31'd0, valid0[0]},    32'd0);
        drv(3'b110, 4'd3, 16'd2);
        drv(3'b110, 4'd3, 16'd2);
        push_all(16'd18);
        drv(3'b101, 4'd3, 16'd2);
        push_all(16'd0);
        drv(3'b101, 4'd3, 16'd2);
        drain();

        // Flush and execute together: 10 accumulated plus product 6.
        drv(3'b110, 4'd5, 16'd2);
        push_all(16'd16);
        drv(3'b111, 4'd3, 16'd2);
        push_all(16'd0);
        drv(3'b101, 4'd0, 16'd2);
        drain();

        // Weights survive the excursion into output-stationary mode.
        push_row(tbl[0].e);
        drv(3'b010, tbl[0].w, tbl[0].n);
        drain();

        // Saturating vs wrapping with weight 7 in column 0 only.
        pulse_reset();
        drv(3'b001, 4'd7, 16'd0);
        drain();
        push_row({{7{16'h7FFF}}, 16'h8030});
        drv(3'b010, 4'd7, 16'h7FFF);
        chk("sat_pos_col0",   {16'd0, out_s1[15:0]}, 32'h7FFF);
        chk("sat_pos_valid0", {31'd0, valid1[0]},    32'd1);
        drain();
        push_row({{7{16'h8000}}, 16'h7FC8});
        drv(3'b010, 4'h8, 16'h8000);
        chk("sat_neg_col0",   {16'd0, out_s1[15:0]}, 32'h8000);
        drain();

        // Reset mid-accumulate discards the partial sums.
        drv(3'b110, 4'd3, 16'd2);
        drv(3'b110, 4'd3, 16'd2);
        pulse_reset();
        push_all(16'd0);
        drv(3'b101, 4'd0, 16'd2);
        drain();

        // Reset mid-load: columns 0..2 loaded, then a fresh load restarts at column 0.
        drv(3'b001, 4'd1, 16'd0);
        drv(3'b001, 4'd2, 16'd0);
        drv(3'b001, 4'd3, 16'd0);
        drv(3'b000, 4'd0, 16'd0);
        drv(3'b000, 4'd0, 16'd0);
        pulse_reset();
        chk("midload_out_e",  {28'd0, out_e0},  32'd0);
        chk("midload_inst_e", {29'd0, inst_e0}, 32'd0);
        drv(3'b001, 4'd6, 16'd0);
        drain();
        push_row({{7{16'd0}}, 16'd6});
        drv(3'b010, 4'd1, 16'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
